// File: rtl/sdram_toggle_port_responder.sv
// Purpose: toggle req/ack port responder plus polled CPU ROM fetch, arbitrated onto one 16-bit memory.
// Latency: port write acks 2 edges after pending is sampled; reads complete READ_LATENCY edges after issue.
// Backpressure: one memory op at a time; port ops win over CPU fetches, stalling the CPU path.
module sdram_toggle_port_responder #(
    parameter int ADDR_W       = 23,
    parameter int READ_LATENCY = 2
) (
    input  logic              clock_48,
    input  logic              reset,
    input  logic              port_req,
    output logic              port_ack,
    input  logic [ADDR_W-1:0] port_a,
    input  logic              port_we,
    input  logic [1:0]        port_ds,
    input  logic [15:0]       port_d,
    output logic [15:0]       port_q,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [15:0]       cpu_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_d,
    input  logic [15:0]       mem_q
);

    typedef enum logic [1:0] {IDLE, WR, RD_PORT, RD_CPU} state_t;

    // Count value on the edge whose mem_q sample holds the read data.
    localparam logic [2:0] CNT_LAST = 3'(READ_LATENCY - 1);

    state_t              state, state_nxt;
    logic [2:0]          cnt, cnt_nxt;
    logic                req_lat, req_lat_nxt;
    logic                cpu_valid, cpu_valid_nxt;
    logic [ADDR_W-1:0]   cpu_addr_last, cpu_addr_last_nxt;
    logic                port_ack_nxt;
    logic [15:0]         port_q_nxt, cpu_q_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic                mem_we_nxt;
    logic [1:0]          mem_be_nxt;
    logic [15:0]         mem_d_nxt;

    logic pending;
    logic cpu_stale;

    assign pending   = (port_req != port_ack);
    assign cpu_stale = !cpu_valid || (cpu_addr != cpu_addr_last);

    // State and all registered outputs; reset abandons any in-flight op without acking it.
    always_ff @(posedge clock_48 or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 3'd0;
            req_lat       <= 1'b0;
            cpu_valid     <= 1'b0;
            cpu_addr_last <= '0;
            port_ack      <= 1'b0;
            port_q        <= 16'h0000;
            cpu_q         <= 16'h0000;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_be        <= 2'b00;
            mem_d         <= 16'h0000;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            req_lat       <= req_lat_nxt;
            cpu_valid     <= cpu_valid_nxt;
            cpu_addr_last <= cpu_addr_last_nxt;
            port_ack      <= port_ack_nxt;
            port_q        <= port_q_nxt;
            cpu_q         <= cpu_q_nxt;
            mem_addr      <= mem_addr_nxt;
            mem_we        <= mem_we_nxt;
            mem_be        <= mem_be_nxt;
            mem_d         <= mem_d_nxt;
        end
    end

    // Arbiter: port op first, then CPU refetch when its address moved or nothing fetched yet.
    always_comb begin
        state_nxt         = state;
        cnt_nxt           = cnt;
        req_lat_nxt       = req_lat;
        cpu_valid_nxt     = cpu_valid;
        cpu_addr_last_nxt = cpu_addr_last;
        port_ack_nxt      = port_ack;
        port_q_nxt        = port_q;
        cpu_q_nxt         = cpu_q;
        mem_addr_nxt      = mem_addr;
        mem_we_nxt        = mem_we;
        mem_be_nxt        = mem_be;
        mem_d_nxt         = mem_d;

        case (state)
            IDLE: begin
                if (pending) begin
                    // Ack later returns this latched value, so extra toggles stay pending.
                    req_lat_nxt  = port_req;
                    mem_addr_nxt = port_a;
                    if (port_we) begin
                        mem_be_nxt = port_ds;
                        mem_d_nxt  = port_d;
                        mem_we_nxt = 1'b1;
                        state_nxt  = WR;
                    end else begin
                        cnt_nxt   = 3'd0;
                        state_nxt = RD_PORT;
                    end
                end else if (cpu_stale) begin
                    mem_addr_nxt      = cpu_addr;
                    cpu_addr_last_nxt = cpu_addr;
                    cnt_nxt           = 3'd0;
                    state_nxt         = RD_CPU;
                end
            end
            WR: begin
                mem_we_nxt   = 1'b0;
                mem_be_nxt   = 2'b00;
                port_ack_nxt = req_lat;
                state_nxt    = IDLE;
            end
            RD_PORT: begin
                cnt_nxt = cnt + 3'd1;
                if (cnt == CNT_LAST) begin
                    port_q_nxt   = mem_q;
                    port_ack_nxt = req_lat;
                    state_nxt    = IDLE;
                end
            end
            RD_CPU: begin
                cnt_nxt = cnt + 3'd1;
                if (cnt == CNT_LAST) begin
                    cpu_q_nxt     = mem_q;
                    cpu_valid_nxt = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sdram_toggle_port_responder.sv
// Bench for the toggle port responder: directed scenarios plus a random port/CPU run.
// Latency: memory models give 1, 2 and 7 edge read latency on three instances.
// Backpressure: each port op waits for its ack under a cycle bound before the next starts.
module tb_sdram_toggle_port_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // Main instance, READ_LATENCY = 2
    logic        port_req = 1'b0, port_we = 1'b0;
    logic [22:0] port_a = '0, cpu_addr = 23'h10;
    logic [1:0]  port_ds = 2'b00;
    logic [15:0] port_d = 16'h0;
    logic        port_ack, m_we;
    logic [15:0] port_q, cpu_q, m_d, mem_q0;
    logic [22:0] m_addr;
    logic [1:0]  m_be;

    sdram_toggle_port_responder #(.ADDR_W(23), .READ_LATENCY(2)) u_dut (
        .clock_48(clk), .reset(rst), .port_req(port_req), .port_ack(port_ack),
        .port_a(port_a), .port_we(port_we), .port_ds(port_ds), .port_d(port_d),
        .port_q(port_q), .cpu_addr(cpu_addr), .cpu_q(cpu_q), .mem_addr(m_addr),
        .mem_we(m_we), .mem_be(m_be), .mem_d(m_d), .mem_q(mem_q0));

    // Latency sweep instances, READ_LATENCY = 1 and 7, read-only traffic
    logic        s_req1 = 1'b0, s_req7 = 1'b0, s_we = 1'b0;
    logic [22:0] s_a = '0, s_cpu = '0;
    logic [1:0]  s_ds = 2'b00;
    logic [15:0] s_d = 16'h0;
    logic        ack1, ack7, mwe1, mwe7;
    logic [15:0] q1, q7, cq1, cq7, md1, md7, mq1, mq7;
    logic [22:0] ma1, ma7;
    logic [1:0]  mbe1, mbe7;

    sdram_toggle_port_responder #(.ADDR_W(23), .READ_LATENCY(1)) u_l1 (
        .clock_48(clk), .reset(rst), .port_req(s_req1), .port_ack(ack1),
        .port_a(s_a), .port_we(s_we), .port_ds(s_ds), .port_d(s_d),
        .port_q(q1), .cpu_addr(s_cpu), .cpu_q(cq1), .mem_addr(ma1),
        .mem_we(mwe1), .mem_be(mbe1), .mem_d(md1), .mem_q(mq1));

    sdram_toggle_port_responder #(.ADDR_W(23), .READ_LATENCY(7)) u_l7 (
        .clock_48(clk), .reset(rst), .port_req(s_req7), .port_ack(ack7),
        .port_a(s_a), .port_we(s_we), .port_ds(s_ds), .port_d(s_d),
        .port_q(q7), .cpu_addr(s_cpu), .cpu_q(cq7), .mem_addr(ma7),
        .mem_we(mwe7), .mem_be(mbe7), .mem_d(md7), .mem_q(mq7));

    // Memory models, indexed by the low 8 address bits
    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    logic [15:0] mem7 [256];
    logic [15:0] refm [256];
    logic [15:0] q0_r;
    logic [15:0] p7 [6];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] <= 16'h0000;
            mem1[i] <= {i[7:0], ~i[7:0]};
            mem7[i] <= {i[7:0], ~i[7:0]};
        end
        mem0[8'h10] <= 16'hBEEF;
        mem0[8'h20] <= 16'h1357;
        mem0[8'h30] <= 16'h2468;
    end

    // Latency 2: one register stage after the address
    always @(posedge clk) begin
        if (m_we) begin
            if (m_be[0]) mem0[m_addr[7:0]][7:0]  <= m_d[7:0];
            if (m_be[1]) mem0[m_addr[7:0]][15:8] <= m_d[15:8];
        end
        q0_r <= mem0[m_addr[7:0]];
    end
    assign mem_q0 = q0_r;

    // Latency 1: combinational read
    always @(posedge clk) begin
        if (mwe1) begin
            if (mbe1[0]) mem1[ma1[7:0]][7:0]  <= md1[7:0];
            if (mbe1[1]) mem1[ma1[7:0]][15:8] <= md1[15:8];
        end
    end
    assign mq1 = mem1[ma1[7:0]];

    // Latency 7: six register stages
    always @(posedge clk) begin
        if (mwe7) begin
            if (mbe7[0]) mem7[ma7[7:0]][7:0]  <= md7[7:0];
            if (mbe7[1]) mem7[ma7[7:0]][15:8] <= md7[15:8];
        end
        p7[0] <= mem7[ma7[7:0]];
        for (int i = 1; i < 6; i++) p7[i] <= p7[i-1];
    end
    assign mq7 = p7[5];

    // Activity monitors for the random run
    int   we_hi = 0, ack_tog = 0;
    logic ack_prev = 1'b0;
    always @(negedge clk) begin
        if (m_we === 1'b1) we_hi++;
        if (port_ack !== ack_prev) ack_tog++;
        ack_prev = port_ack;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One port transfer with a bounded wait; returns read data and edges to ack.
    task automatic do_op(input logic we, input logic [7:0] a, input logic [1:0] ds,
                         input logic [15:0] d, output logic [15:0] q, output int n);
        port_we  = we;
        port_a   = {15'h0, a};
        port_ds  = ds;
        port_d   = d;
        port_req = ~port_req;
        n = 0;
        while (port_ack !== port_req && n < 40) begin
            tick(1);
            n++;
        end
        q = port_q;
        checks++;
        if (port_ack !== port_req) begin
            failures++;
            $display("FAIL op_timeout addr=%h ack=%b req=%b", a, port_ack, port_req);
        end else if (we) begin
            if (ds[0]) refm[a][7:0]  = d[7:0];
            if (ds[1]) refm[a][15:8] = d[15:8];
        end else if (port_q !== refm[a]) begin
            failures++;
            $display("FAIL op_read addr=%h got=%h exp=%h", a, port_q, refm[a]);
        end
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if (port_ack !== 1'b0 || m_we !== 1'b0 || port_q !== 16'h0 || cpu_q !== 16'h0 ||
            m_addr !== 23'h0 || m_be !== 2'b00 || m_d !== 16'h0) begin
            failures++;
            $display("FAIL reset_values ack=%b we=%b pq=%h cq=%h addr=%h be=%b d=%h exp all zero",
                     port_ack, m_we, port_q, cpu_q, m_addr, m_be, m_d);
        end
    endtask

    task automatic test_cpu_fetch();
        rst = 1'b0;
        tick(1);
        checks++;
        if (m_addr !== 23'h10 || cpu_q !== 16'h0) begin
            failures++;
            $display("FAIL cpu_issue addr=%h cq=%h exp addr=000010 cq=0000", m_addr, cpu_q);
        end
        tick(1);
        checks++;
        if (cpu_q !== 16'h0) begin
            failures++;
            $display("FAIL cpu_early cq=%h exp=0000", cpu_q);
        end
        tick(1);
        checks++;
        if (cpu_q !== 16'hBEEF) begin
            failures++;
            $display("FAIL cpu_data cq=%h exp=beef", cpu_q);
        end
        tick(4);
    endtask

    // Also proves the CPU path is idle: the write must issue on the very next edge.
    task automatic test_write();
        port_we = 1'b1; port_a = 23'h123; port_ds = 2'b01; port_d = 16'hA55A;
        port_req = 1'b1;
        tick(1);
        checks++;
        if (m_we !== 1'b1 || m_be !== 2'b01 || m_d !== 16'hA55A || m_addr !== 23'h123 || port_ack !== 1'b0) begin
            failures++;
            $display("FAIL wr_issue we=%b be=%b d=%h addr=%h ack=%b exp 1 01 a55a 000123 0",
                     m_we, m_be, m_d, m_addr, port_ack);
        end
        tick(1);
        checks++;
        if (m_we !== 1'b0 || m_be !== 2'b00 || port_ack !== 1'b1) begin
            failures++;
            $display("FAIL wr_done we=%b be=%b ack=%b exp 0 00 1", m_we, m_be, port_ack);
        end
        refm[8'h23][7:0] = 8'h5A;
    endtask

    task automatic test_read();
        port_we = 1'b0; port_a = 23'h123;
        port_req = 1'b0;
        tick(2);
        checks++;
        if (port_ack !== 1'b1 || m_addr !== 23'h123) begin
            failures++;
            $display("FAIL rd_wait ack=%b addr=%h exp 1 000123", port_ack, m_addr);
        end
        tick(1);
        checks++;
        if (port_ack !== 1'b0 || port_q !== 16'h005A) begin
            failures++;
            $display("FAIL rd_data ack=%b pq=%h exp 0 005a", port_ack, port_q);
        end
    endtask

    task automatic test_port_vs_cpu();
        cpu_addr = 23'h20;
        tick(1);
        port_we = 1'b0; port_a = 23'h10; port_req = 1'b1;
        cpu_addr = 23'h30;
        tick(2);
        checks++;
        if (cpu_q !== 16'h1357 || m_addr !== 23'h20 || port_ack !== 1'b0) begin
            failures++;
            $display("FAIL arb_cpu_first cq=%h addr=%h ack=%b exp 1357 000020 0", cpu_q, m_addr, port_ack);
        end
        tick(1);
        checks++;
        if (m_addr !== 23'h10) begin
            failures++;
            $display("FAIL arb_port_issue addr=%h exp=000010", m_addr);
        end
        tick(2);
        checks++;
        if (port_ack !== 1'b1 || port_q !== 16'hBEEF) begin
            failures++;
            $display("FAIL arb_port_data ack=%b pq=%h exp 1 beef", port_ack, port_q);
        end
        tick(1);
        checks++;
        if (m_addr !== 23'h30) begin
            failures++;
            $display("FAIL arb_refetch addr=%h exp=000030", m_addr);
        end
        tick(2);
        checks++;
        if (cpu_q !== 16'h2468) begin
            failures++;
            $display("FAIL arb_refetch_data cq=%h exp=2468", cpu_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q;
        int n;
        do_op(1'b1, 8'h50, 2'b11, 16'hCAFE, q, n);
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL b2b_wr_lat got=%0d exp=2", n);
        end
        do_op(1'b1, 8'h50, 2'b10, 16'h7788, q, n);
        do_op(1'b0, 8'h50, 2'b00, 16'h0000, q, n);
        checks++;
        if (n !== 3 || q !== 16'h77FE) begin
            failures++;
            $display("FAIL b2b_rd lat=%0d q=%h exp 3 77fe", n, q);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] q;
        int n;
        // Reset inside WR; the request (req=1) stays pending across reset.
        port_we = 1'b1; port_a = 23'h40; port_ds = 2'b11; port_d = 16'h1111;
        port_req = 1'b1;
        tick(1);
        rst = 1'b1;
        #1;
        checks++;
        if (m_we !== 1'b0 || port_ack !== 1'b0 || m_addr !== 23'h0) begin
            failures++;
            $display("FAIL rst_in_wr we=%b ack=%b addr=%h exp 0 0 000000", m_we, port_ack, m_addr);
        end
        tick(2);
        rst = 1'b0;
        tick(1);
        checks++;
        if (m_we !== 1'b1 || m_addr !== 23'h40) begin
            failures++;
            $display("FAIL rst_wr_reserve we=%b addr=%h exp 1 000040", m_we, m_addr);
        end
        tick(1);
        checks++;
        if (port_ack !== 1'b1) begin
            failures++;
            $display("FAIL rst_wr_ack ack=%b exp=1", port_ack);
        end
        refm[8'h40] = 16'h1111;
        tick(4);
        // Reset inside RD_PORT after one ordinary op brings req back to 0.
        do_op(1'b1, 8'h60, 2'b11, 16'h6060, q, n);
        port_we = 1'b0; port_a = 23'h10; port_req = 1'b1;
        tick(1);
        rst = 1'b1;
        #1;
        checks++;
        if (m_we !== 1'b0 || port_ack !== 1'b0 || port_q !== 16'h0) begin
            failures++;
            $display("FAIL rst_in_rd we=%b ack=%b pq=%h exp 0 0 0000", m_we, port_ack, port_q);
        end
        tick(2);
        rst = 1'b0;
        tick(3);
        checks++;
        if (port_ack !== 1'b1 || port_q !== 16'hBEEF) begin
            failures++;
            $display("FAIL rst_rd_reserve ack=%b pq=%h exp 1 beef", port_ack, port_q);
        end
        tick(6);
    endtask

    task automatic test_latency_sweep();
        int f1, f7;
        tick(10);
        checks++;
        if (cq1 !== 16'h00FF || cq7 !== 16'h00FF) begin
            failures++;
            $display("FAIL sweep_cpu cq1=%h cq7=%h exp 00ff", cq1, cq7);
        end
        f1 = -1; f7 = -1;
        s_a = 23'h33;
        s_req1 = 1'b1; s_req7 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (f1 < 0 && ack1 === s_req1) f1 = k;
            if (f7 < 0 && ack7 === s_req7) f7 = k;
        end
        checks++;
        if (f1 !== 2 || q1 !== 16'h33CC) begin
            failures++;
            $display("FAIL sweep_l1 edge=%0d q=%h exp 2 33cc", f1, q1);
        end
        checks++;
        if (f7 !== 8 || q7 !== 16'h33CC) begin
            failures++;
            $display("FAIL sweep_l7 edge=%0d q=%h exp 8 33cc", f7, q7);
        end
    endtask

    task automatic test_random();
        logic [15:0] q;
        int n, we0, tog0, wexp;
        tick(2);
        we0 = we_hi; tog0 = ack_tog; wexp = 0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) cpu_addr = 23'($urandom_range(64, 127));
            if ($urandom_range(0, 1) == 1) begin
                do_op(1'b1, 8'($urandom_range(64, 127)), 2'($urandom_range(0, 3)),
                      16'($urandom), q, n);
                wexp++;
            end else begin
                do_op(1'b0, 8'($urandom_range(64, 127)), 2'b00, 16'h0, q, n);
            end
            tick($urandom_range(0, 3));
        end
        tick(4);
        checks++;
        if (we_hi - we0 !== wexp || ack_tog - tog0 !== 40) begin
            failures++;
            $display("FAIL rand_counts we_cycles=%0d exp=%0d acks=%0d exp=40",
                     we_hi - we0, wexp, ack_tog - tog0);
        end
        cpu_addr = 23'h20;
        tick(8);
        cpu_addr = 23'h45;
        tick(8);
        checks++;
        if (cpu_q !== refm[8'h45]) begin
            failures++;
            $display("FAIL rand_cpu cq=%h exp=%h", cpu_q, refm[8'h45]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) refm[i] = 16'h0000;
        refm[8'h10] = 16'hBEEF;
        refm[8'h20] = 16'h1357;
        refm[8'h30] = 16'h2468;
        #1;
        test_reset();
        test_cpu_fetch();
        test_write();
        test_read();
        test_port_vs_cpu();
        test_back_to_back();
        test_reset_mid();
        test_latency_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
